// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the command-register bus arbiter.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        GAP   = 2'd2
    } bus_state_e;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int GAP_CNT_W  = 4;

endpackage

// File: rtl/reg_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the closest candidate after 'last' wins.
    always_comb begin
        winner = last;
        valid  = 1'b0;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter for the shared command-register write bus: one latch per grant, then a quiet gap.
// Optional REG_BUS_ARB_PRIO0_EN gives requester 0 fixed absolute priority.
module reg_bus_arb
    import reg_bus_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 1,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                     bclk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          reqIn,
    input  logic [NREQ*ADDR_W-1:0]   addrIn,
    input  logic [NREQ*DATA_W-1:0]   dataIn,
    output logic [NREQ-1:0]          ackOut,
    output logic [ADDR_W-1:0]        addrOut,
    output logic [DATA_W-1:0]        dataOut,
    output logic                     latchOut,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    bus_state_e           state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     rr_winner;
    logic [IDX_W-1:0]     winner;
    logic                 rr_valid;
    logic                 grant_vld;
    logic                 upd_last;
    logic [NREQ-1:0]      pick_req;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic [NREQ-1:0]      sel_ack;

`ifdef REG_BUS_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation and leaves the pointer untouched.
    assign pick_req  = reqIn & ~NREQ'(1);
    assign winner    = reqIn[0] ? '0 : rr_winner;
    assign grant_vld = reqIn[0] | rr_valid;
    assign upd_last  = ~reqIn[0];
`else
    assign pick_req  = reqIn;
    assign winner    = rr_winner;
    assign grant_vld = rr_valid;
    assign upd_last  = 1'b1;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (pick_req),
        .last   (last),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_ack  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_addr   = addrIn[i*ADDR_W +: ADDR_W];
                sel_data   = dataIn[i*DATA_W +: DATA_W];
                sel_ack[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= IDX_W'(NREQ - 1);
            gap_cnt  <= '0;
            ackOut   <= '0;
            latchOut <= 1'b0;
            addrOut  <= '0;
            dataOut  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ackOut   <= '0;
                    latchOut <= 1'b0;
                    if (grant_vld) begin
                        addrOut  <= sel_addr;
                        dataOut  <= sel_data;
                        ackOut   <= sel_ack;
                        latchOut <= 1'b1;
                        if (upd_last) last <= winner;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
                    ackOut   <= '0;
                    latchOut <= 1'b0;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else begin
                        state   <= IDLE;
                    end
                end
                GAP: begin
                    // Requests are deliberately not sampled here; the bus must stay quiet.
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    ackOut   <= '0;
                    latchOut <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_bus_arb.sv
// Bench for reg_bus_arb: two instances (gap 1 and gap 0) share stimulus and are checked every cycle
// against an occupancy-countdown model, plus directed checks for the key scenarios.
module tb_reg_bus_arb;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;

    logic                 bclk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   addr_bus;
    logic [NREQ*DW-1:0]   data_bus;

    logic [NREQ-1:0] ack_a, ack_b;
    logic [AW-1:0]   addr_a, addr_b;
    logic [DW-1:0]   data_a, data_b;
    logic            latch_a, latch_b, busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    int              gaps [2] = '{1, 0};
    int              cool [2];
    int              lst  [2];
    logic [NREQ-1:0] e_ack [2];
    logic            e_latch [2];
    logic            e_busy [2];
    logic [AW-1:0]   e_addr [2];
    logic [DW-1:0]   e_data [2];

    always #5 bclk = ~bclk;

    reg_bus_arb #(.NREQ(NREQ), .GAP_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) dut (
        .bclk(bclk), .rst(rst), .reqIn(req), .addrIn(addr_bus), .dataIn(data_bus),
        .ackOut(ack_a), .addrOut(addr_a), .dataOut(data_a), .latchOut(latch_a), .busy(busy_a)
    );

    reg_bus_arb #(.NREQ(NREQ), .GAP_CYCLES(0), .ADDR_W(AW), .DATA_W(DW)) dut_g0 (
        .bclk(bclk), .rst(rst), .reqIn(req), .addrIn(addr_bus), .dataIn(data_bus),
        .ackOut(ack_b), .addrOut(addr_b), .dataOut(data_b), .latchOut(latch_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester found searching lst+1, lst+2, ... modulo NREQ; -1 if none.
    function automatic int rr_search(input logic [NREQ-1:0] r, input int l);
        int w;
        w = -1;
        for (int k = NREQ; k >= 1; k--)
            if (r[(l + k) % NREQ]) w = (l + k) % NREQ;
        return w;
    endfunction

    // cool = cycles the bus stays occupied after a grant (latch cycle + quiet gap).
    task automatic model_step(input int u);
        int w;
        if (rst) begin
            cool[u] = 0; lst[u] = NREQ - 1;
            e_ack[u] = '0; e_latch[u] = 1'b0; e_addr[u] = '0; e_data[u] = '0;
        end else begin
            e_ack[u] = '0; e_latch[u] = 1'b0;
            if (cool[u] > 0) begin
                cool[u]--;
            end else if (req != '0) begin
`ifdef REG_BUS_ARB_PRIO0_EN
                if (req[0]) w = 0;
                else begin
                    w = rr_search(req & 4'b1110, lst[u]);
                    lst[u] = w;
                end
`else
                w = rr_search(req, lst[u]);
                lst[u] = w;
`endif
                e_ack[u]   = 4'(1 << w);
                e_latch[u] = 1'b1;
                e_addr[u]  = addr_bus[w*AW +: AW];
                e_data[u]  = data_bus[w*DW +: DW];
                cool[u]    = 1 + gaps[u];
            end
        end
        e_busy[u] = (cool[u] > 0);
    endtask

    task automatic tick();
        @(posedge bclk);
        model_step(0);
        model_step(1);
        #1;
        check("g1_ack",   64'(ack_a),   64'(e_ack[0]));
        check("g1_latch", 64'(latch_a), 64'(e_latch[0]));
        check("g1_busy",  64'(busy_a),  64'(e_busy[0]));
        check("g1_addr",  64'(addr_a),  64'(e_addr[0]));
        check("g1_data",  64'(data_a),  64'(e_data[0]));
        check("g0_ack",   64'(ack_b),   64'(e_ack[1]));
        check("g0_latch", 64'(latch_b), 64'(e_latch[1]));
        check("g0_busy",  64'(busy_b),  64'(e_busy[1]));
        check("g0_addr",  64'(addr_b),  64'(e_addr[1]));
        check("g0_data",  64'(data_b),  64'(e_data[1]));
        @(negedge bclk);
    endtask

    initial begin
        logic [NREQ-1:0] exp_ack;
        rst = 1'b1; req = '0; addr_bus = '0; data_bus = '0;
        for (int i = 0; i < 2; i++) begin
            cool[i] = 0; lst[i] = NREQ - 1; e_ack[i] = 'x; e_latch[i] = 1'bx;
            e_busy[i] = 1'bx; e_addr[i] = 'x; e_data[i] = 'x;
        end
        @(negedge bclk);
        tick();
        check("reset_latch", 64'(latch_a), 64'(0));
        check("reset_busy",  64'(busy_a),  64'(0));
        tick();
        rst = 1'b0;
        tick();

        // Single request from requester 2
        req = 4'b0100;
        addr_bus[2*AW +: AW] = 8'h12;
        data_bus[2*DW +: DW] = 32'h0000_0021;
        tick();
        check("single_latch", 64'(latch_a), 64'(1));
        check("single_ack",   64'(ack_a),   64'(4'b0100));
        check("single_addr",  64'(addr_a),  64'(8'h12));
        check("single_data",  64'(data_a),  64'(32'h21));
        req = '0;
        tick();
        check("single_busy_gap", 64'(busy_a), 64'(1));
        tick();
        check("single_idle", 64'(busy_a), 64'(0));
        tick();

        // All requesting, gap 1: rotation and latch spacing
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
`ifdef REG_BUS_ARB_PRIO0_EN
            exp_ack = 4'b0001;
`else
            exp_ack = 4'(1 << (g % 4));
`endif
            check("rr_order", 64'(ack_a), 64'(exp_ack));
            tick();
            check("rr_no_back2back", 64'(latch_a), 64'(0));
            tick();
        end

        // Gap 0: two requesters alternate every other cycle
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0011;
        for (int g = 0; g < 4; g++) begin
            tick();
`ifdef REG_BUS_ARB_PRIO0_EN
            exp_ack = 4'b0001;
`else
            exp_ack = (g % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            check("g0_alt_ack", 64'(ack_b), 64'(exp_ack));
            tick();
            check("g0_alt_gap", 64'(latch_b), 64'(0));
        end

        // Withdrawal: requester 1 pulses only during the gap
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0001; tick();
        req = '0;      tick();
        req = 4'b0010; tick();
        check("withdraw_ack",   64'(ack_a),   64'(0));
        check("withdraw_latch", 64'(latch_a), 64'(0));
        req = '0; tick();
        check("withdraw_ack2",  64'(ack_a),   64'(0));
        tick();

        // Reset in the latch cycle
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        repeat (4) tick();
        check("pre_rst_latch", 64'(latch_a), 64'(1));
        rst = 1'b1; tick();
        check("midrst_latch", 64'(latch_a), 64'(0));
        check("midrst_ack",   64'(ack_a),   64'(0));
        check("midrst_busy",  64'(busy_a),  64'(0));
        rst = 1'b0; tick();
        check("post_rst_grant0", 64'(ack_a), 64'(4'b0001));
        req = '0; tick(); tick();

`ifdef REG_BUS_ARB_PRIO0_EN
        // Priority: requester 0 preempts the rotation among 1..3 without disturbing it
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1110;
        tick();
        check("prio_first", 64'(ack_a), 64'(4'b0010));
        repeat (5) tick();
        req = 4'b1111; tick();
        check("prio_r0", 64'(ack_a), 64'(4'b0001));
        req = 4'b1110;
        repeat (3) tick();
        check("prio_resume", 64'(ack_a), 64'(4'b1000));
        req = '0; tick(); tick();
`endif

        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            req      = 4'($urandom_range(0, 15));
            addr_bus = 32'($urandom);
            data_bus = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            rst      = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0; req = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
